// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding, access-type codes and defaults for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    localparam logic [1:0] STORE_SB = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SW = 2'b10;

    localparam int LSU_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational misalignment check, store lane steering and load extraction
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic        is_write,
    input  logic [2:0]  load,
    input  logic [1:0]  store,
    input  logic [31:0] wr_data,
    output logic        misaligned,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic [1:0]  rd_addr_lo,
    input  logic [2:0]  rd_load,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_ext
);

    logic        is_half;
    logic        is_word;
    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Unlisted load/store codes fall into the word case.
    always_comb begin
        if (is_write) begin
            is_half = (store == STORE_SH);
            is_word = (store != STORE_SB) && (store != STORE_SH);
        end else begin
            is_half = (load == LOAD_LH) || (load == LOAD_LHU);
            is_word = (load != LOAD_LB) && (load != LOAD_LBU) && !is_half;
        end
        misaligned = (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
    end

    always_comb begin
        case (store)
            STORE_SB: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{wr_data[7:0]}};
            end
            STORE_SH: begin
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wr_data[15:0]}};
            end
            STORE_SW: begin
                wstrb = 4'b1111;
                wdata = wr_data;
            end
            default: begin
                wstrb = 4'b1111;
                wdata = wr_data;
            end
        endcase
    end

    assign rd_shift = rdata >> {rd_addr_lo, 3'b000};
    assign rd_byte  = rd_shift[7:0];
    assign rd_half  = rd_addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (rd_load)
            LOAD_LB:  rdata_ext = {{24{rd_byte[7]}}, rd_byte};
            LOAD_LH:  rdata_ext = {{16{rd_half[15]}}, rd_half};
            LOAD_LBU: rdata_ext = {24'd0, rd_byte};
            LOAD_LHU: rdata_ext = {16'd0, rd_half};
            LOAD_LW:  rdata_ext = rdata;
            default:  rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - handshaked data-memory port with core stall; LSU_TIMEOUT_EN adds a REQ timeout and BusErr
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Load,
    input  logic [1:0]  Store,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadDataOut,
    output logic        Stall,
    output logic        MisalignedErr,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    lsu_state_t  state;
    lsu_state_t  state_next;
    logic        take;
    logic        timeout_hit;
    logic        misaligned;
    logic [3:0]  acc_wstrb;
    logic [31:0] acc_wdata;
    logic [31:0] rd_ext;
    logic [1:0]  lat_addr_lo;
    logic [2:0]  lat_load;

    lsu_align u_align (
        .addr_lo    (Addr[1:0]),
        .is_write   (MemWrite),
        .load       (Load),
        .store      (Store),
        .wr_data    (WriteData),
        .misaligned (misaligned),
        .wstrb      (acc_wstrb),
        .wdata      (acc_wdata),
        .rd_addr_lo (lat_addr_lo),
        .rd_load    (lat_load),
        .rdata      (mem_rdata),
        .rdata_ext  (rd_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        take          = 1'b0;
        Stall         = 1'b0;
        MisalignedErr = 1'b0;
        case (state)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    if (misaligned) begin
                        MisalignedErr = 1'b1;
                    end else begin
                        Stall      = 1'b1;
                        take       = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (mem_ack || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus fields are captured once at acceptance so they stay frozen through REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_wstrb   <= 4'd0;
            lat_addr_lo <= 2'd0;
            lat_load    <= 3'd0;
            ReadDataOut <= 32'd0;
        end else begin
            mem_req <= (state_next == REQ);
            if (take) begin
                mem_addr    <= {Addr[31:2], 2'b00};
                mem_we      <= MemWrite;
                mem_wdata   <= acc_wdata;
                mem_wstrb   <= MemWrite ? acc_wstrb : 4'd0;
                lat_addr_lo <= Addr[1:0];
                lat_load    <= Load;
            end
            if ((state == REQ) && mem_ack && !mem_we) begin
                ReadDataOut <= rd_ext;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;
    logic       bus_err_q;

    // Counter sits at zero outside REQ, so it starts fresh on every REQ entry.
    assign timeout_hit = (state == REQ) && !mem_ack && (tmo_cnt == TIMEOUT_LAST);
    assign BusErr      = bus_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt   <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_cnt   <= (state == REQ) ? tmo_cnt + 8'd1 : 8'd0;
            bus_err_q <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign BusErr      = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a behavioural memory-access model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Load;
    logic [1:0]  Store;
    logic [31:0] Addr, WriteData;
    logic [31:0] ReadDataOut;
    logic        Stall, MisalignedErr, BusErr;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_load = 32'd0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .Load          (Load),
        .Store         (Store),
        .Addr          (Addr),
        .WriteData     (WriteData),
        .ReadDataOut   (ReadDataOut),
        .Stall         (Stall),
        .MisalignedErr (MisalignedErr),
        .BusErr        (BusErr),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int acc_size(input logic w, input logic [2:0] ld, input logic [1:0] st);
        if (w) return (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : 4;
        case (ld)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] ld, input logic [1:0] off, input logic [31:0] word);
        logic [31:0] v;
        int sz;
        sz = acc_size(1'b0, ld, 2'd0);
        v  = word >> (8 * off);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (ld == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (ld == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_strb(input int sz, input logic [1:0] off);
        if (sz == 1) return 32'(1 << off);
        if (sz == 2) return 32'(3 << off);
        return 32'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] wd);
        if (sz == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    task automatic do_access(input logic rd, input logic wr, input logic [2:0] ld, input logic [1:0] st,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                             input int delay);
        int sz;
        int stalls;
        sz = acc_size(wr, ld, st);
        stalls = 0;
        MemRead = rd; MemWrite = wr; Load = ld; Store = st; Addr = addr; WriteData = wd; mem_ack = 1'b0;
        #1;
        if ((addr % 32'(sz)) != 0) begin
            check_eq("mis_err", MisalignedErr, 1'b1);
            check_eq("mis_stall", Stall, 1'b0);
            @(posedge clk); #1;
            check_eq("mis_no_req", mem_req, 1'b0);
            MemRead = 1'b0; MemWrite = 1'b0;
            return;
        end
        check_eq("acc_no_mis", MisalignedErr, 1'b0);
        stalls += int'(Stall);
        @(posedge clk); #1;
        Addr = $urandom; WriteData = $urandom; Load = 3'($urandom); Store = 2'($urandom);
        for (int i = 0; i <= delay; i++) begin
            mem_rdata = (i == delay) ? rdata : $urandom;
            mem_ack   = (i == delay);
            #1;
            check_eq("req_req", mem_req, 1'b1);
            check_eq("req_mis", MisalignedErr, 1'b0);
            check_eq("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
            check_eq("req_we", mem_we, wr);
            check_eq("req_wstrb", mem_wstrb, wr ? exp_strb(sz, addr[1:0]) : 32'd0);
            if (wr) check_eq("req_wdata", mem_wdata, exp_wdata(sz, wd));
            stalls += int'(Stall);
            @(posedge clk); #1;
        end
        mem_ack = 1'($urandom);
        #1;
        check_eq("done_stall", Stall, 1'b0);
        check_eq("done_req", mem_req, 1'b0);
        check_eq("done_mis", MisalignedErr, 1'b0);
        check_eq("done_buserr", BusErr, 1'b0);
        if (!wr) last_load = exp_load(ld, addr[1:0], rdata);
        check_eq("done_rdata", ReadDataOut, last_load);
        check_eq("stall_cycles", 32'(stalls), 32'(delay + 2));
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Load = 3'd0; Store = 2'd0;
        Addr = 32'd0; WriteData = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req", mem_req, 1'b0);
        check_eq("rst_stall", Stall, 1'b0);
        check_eq("rst_rdata", ReadDataOut, 32'd0);
        check_eq("rst_wstrb", mem_wstrb, 4'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_buserr", BusErr, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_access(1'b0, 1'b1, 3'd0, 2'b10, 32'h100, 32'hDEAD_BEEF, 32'd0, 0);
        do_access(1'b0, 1'b1, 3'd0, 2'b00, 32'h103, 32'h0000_00A5, 32'd0, 1);
        do_access(1'b1, 1'b0, 3'b000, 2'd0, 32'h202, 32'd0, 32'h12F4_5678, 0);
        check_eq("lb_const", ReadDataOut, 32'hFFFF_FFF4);
        do_access(1'b1, 1'b0, 3'b100, 2'd0, 32'h202, 32'd0, 32'h12F4_5678, 2);
        check_eq("lbu_const", ReadDataOut, 32'h0000_00F4);
        do_access(1'b1, 1'b0, 3'b101, 2'd0, 32'h202, 32'd0, 32'h12F4_5678, 1);
        check_eq("lhu_const", ReadDataOut, 32'h0000_12F4);
        do_access(1'b1, 1'b0, 3'b010, 2'd0, 32'h301, 32'd0, 32'd0, 0);
        check_eq("mis_keeps_rdata", ReadDataOut, 32'h0000_12F4);

        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = int'($urandom % 3);
            do_access(kind != 1, kind != 0, 3'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                      int'($urandom % 4));
            if ($urandom % 4 == 0) begin
                mem_ack = 1'b1;
                @(posedge clk); #1;
                mem_ack = 1'b0;
                check_eq("stray_ack", mem_req, 1'b0);
            end
        end

        do_access(1'b1, 1'b0, 3'b010, 2'd0, 32'h400, 32'd0, 32'hCAFE_F00D, 0);
        MemRead = 1'b1; MemWrite = 1'b0; Load = 3'b010; Addr = 32'h500; mem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("pre_rst_req", mem_req, 1'b1);
        reset = 1'b1; MemRead = 1'b0;
        #1;
        check_eq("midrst_req", mem_req, 1'b0);
        check_eq("midrst_stall", Stall, 1'b0);
        check_eq("midrst_rdata", ReadDataOut, 32'd0);
        last_load = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 3'b001, 2'd0, 32'h602, 32'd0, 32'h8001_7FFF, 1);

`ifdef LSU_TIMEOUT_EN
        MemRead = 1'b1; MemWrite = 1'b0; Load = 3'b010; Addr = 32'h700; mem_ack = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check_eq("tmo_req", mem_req, 1'b1);
            check_eq("tmo_nobus", BusErr, 1'b0);
            @(posedge clk); #1;
        end
        check_eq("tmo_buserr", BusErr, 1'b1);
        check_eq("tmo_stall", Stall, 1'b0);
        check_eq("tmo_req_drop", mem_req, 1'b0);
        check_eq("tmo_rdata", ReadDataOut, last_load);
        @(posedge clk); #1;
        MemRead = 1'b0;
        check_eq("tmo_pulse", BusErr, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
